// File: rtl/thermo_stim_pkg.sv
// thermo_stim_pkg: shared types and helpers for the thermometer stimulus checker.
//   state_e  - checker FSM state encoding
//   step_w() - width of the step index for a given DUT input count
//   thermo() - k-ones thermometer mask, clipped to width (max 64)
package thermo_stim_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_APPLY   = 3'd1,
    S_WAIT    = 3'd2,
    S_COMPARE = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  // Step index spans 0..width inclusive, hence width+1 values.
  function automatic int unsigned step_w(input int unsigned width);
    return (width < 1) ? 1 : $clog2(width + 1);
  endfunction

  function automatic logic [63:0] thermo(input int unsigned k, input int unsigned width);
    logic [63:0] m;
    m = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      if ((i < k) && (i < width)) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/thermo_stim_checker_sat_counter.sv
// sat_counter: saturating up-counter for mismatch counting.
//   clk, rst_n - clock, async active-low reset
//   clr        - synchronous clear (wins over inc)
//   inc        - increment by one, holding at all-ones
//   cnt        - current count
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/thermo_stim_checker.sv
// thermo_stim_checker: drives a thermometer-coded vector into a golden model and a
// netlist in parallel, waits SETTLE cycles per step, compares their outputs with
// 4-state semantics and counts mismatches.
//   clk, rst_n     - clock, async active-low reset
//   start          - run request, honoured only in IDLE or DONE
//   stim           - registered stimulus to both DUTs
//   golden_out     - golden model output
//   netlist_out    - netlist output
//   busy, done     - run in progress / run finished (level)
//   pass           - done with zero mismatches
//   mismatch_cnt   - saturating mismatch count
//   step           - current step index k (0..WIDTH)
// Optional macro THERMO_STIM_FAIL_CAPTURE_EN adds fail_valid, fail_step,
// fail_golden, fail_netlist: a record of the first mismatch of the run.
module thermo_stim_checker
  import thermo_stim_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned SETTLE = 2,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  output logic [WIDTH-1:0]           stim,
  input  logic                       golden_out,
  input  logic                       netlist_out,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [CNT_W-1:0]           mismatch_cnt,
  output logic [step_w(WIDTH)-1:0]   step
`ifdef THERMO_STIM_FAIL_CAPTURE_EN
  ,
  output logic                       fail_valid,
  output logic [step_w(WIDTH)-1:0]   fail_step,
  output logic                       fail_golden,
  output logic                       fail_netlist
`endif
);

  localparam int unsigned SW = step_w(WIDTH);
  localparam int unsigned WW = (SETTLE < 2) ? 1 : $clog2(SETTLE);

  state_e           state, state_nxt;
  logic [WW-1:0]    wait_cnt, wait_nxt;
  logic [SW-1:0]    step_nxt;
  logic [WIDTH-1:0] stim_nxt;
  logic             busy_nxt, done_nxt, pass_nxt;
  logic             cnt_clr_c, cnt_inc_c, mismatch_c;
`ifdef THERMO_STIM_FAIL_CAPTURE_EN
  logic             fv_nxt, fg_nxt, fn_nxt;
  logic [SW-1:0]    fs_nxt;
`endif

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      step     <= '0;
      stim     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
`ifdef THERMO_STIM_FAIL_CAPTURE_EN
      fail_valid   <= 1'b0;
      fail_step    <= '0;
      fail_golden  <= 1'b0;
      fail_netlist <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      step     <= step_nxt;
      stim     <= stim_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      pass     <= pass_nxt;
`ifdef THERMO_STIM_FAIL_CAPTURE_EN
      fail_valid   <= fv_nxt;
      fail_step    <= fs_nxt;
      fail_golden  <= fg_nxt;
      fail_netlist <= fn_nxt;
`endif
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt  = state;
    wait_nxt   = wait_cnt;
    step_nxt   = step;
    stim_nxt   = stim;
    busy_nxt   = busy;
    done_nxt   = done;
    pass_nxt   = pass;
    cnt_clr_c  = 1'b0;
    cnt_inc_c  = 1'b0;
    // Case inequality so X/Z on either DUT output is flagged.
    mismatch_c = (golden_out !== netlist_out);
`ifdef THERMO_STIM_FAIL_CAPTURE_EN
    fv_nxt = fail_valid;
    fs_nxt = fail_step;
    fg_nxt = fail_golden;
    fn_nxt = fail_netlist;
`endif
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt = S_APPLY;
          step_nxt  = '0;
          busy_nxt  = 1'b1;
          done_nxt  = 1'b0;
          pass_nxt  = 1'b0;
          cnt_clr_c = 1'b1;
`ifdef THERMO_STIM_FAIL_CAPTURE_EN
          fv_nxt = 1'b0;
          fs_nxt = '0;
          fg_nxt = 1'b0;
          fn_nxt = 1'b0;
`endif
        end
      end
      S_APPLY: begin
        stim_nxt  = WIDTH'(thermo(32'(step), WIDTH));
        wait_nxt  = '0;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (wait_cnt == WW'(SETTLE - 1)) state_nxt = S_COMPARE;
        else                             wait_nxt  = wait_cnt + WW'(1);
      end
      S_COMPARE: begin
        cnt_inc_c = mismatch_c;
`ifdef THERMO_STIM_FAIL_CAPTURE_EN
        if (mismatch_c && !fail_valid) begin
          fv_nxt = 1'b1;
          fs_nxt = step;
          fg_nxt = golden_out;
          fn_nxt = netlist_out;
        end
`endif
        if (step == SW'(WIDTH)) begin
          state_nxt = S_DONE;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          // A saturating count is nonzero once nonzero, so this matches the post-edge count.
          pass_nxt  = !mismatch_c && (mismatch_cnt == '0);
        end else begin
          step_nxt  = step + SW'(1);
          state_nxt = S_APPLY;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  sat_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr_c),
    .inc   (cnt_inc_c),
    .cnt   (mismatch_cnt)
  );

endmodule

// File: tb/tb_thermo_stim_checker.sv
// Bench for thermo_stim_checker: matching, stuck-at, X netlist, reset abort,
// random runs, and a held-start run on a 2-bit-counter instance.
module tb_thermo_stim_checker;

  localparam int W   = 8;
  localparam int S   = 2;
  localparam int SWT = $clog2(W + 1);
  localparam int RUN = (W + 1) * (S + 2);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic start2 = 1'b0;
  logic xv;
  int   mode = 0;

  logic [W-1:0]   stim, stim2;
  logic           golden, netlist, golden2, netlist2;
  logic           busy, done, pass, busy2, done2, pass2;
  logic [7:0]     cnt;
  logic [1:0]     cnt2;
  logic [SWT-1:0] step, step2;
`ifdef THERMO_STIM_FAIL_CAPTURE_EN
  logic           fv, fg, fn, fv2, fg2, fn2;
  logic [SWT-1:0] fs, fs2;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign golden   = &stim;
  assign golden2  = &stim2;
  assign netlist2 = 1'b1;

  always_comb begin
    case (mode)
      0:       netlist = &stim;
      1:       netlist = 1'b0;
      2:       netlist = 1'b1;
      default: netlist = xv;
    endcase
  end

  thermo_stim_checker #(.WIDTH(W), .SETTLE(S), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stim(stim),
    .golden_out(golden), .netlist_out(netlist),
    .busy(busy), .done(done), .pass(pass), .mismatch_cnt(cnt), .step(step)
`ifdef THERMO_STIM_FAIL_CAPTURE_EN
    , .fail_valid(fv), .fail_step(fs), .fail_golden(fg), .fail_netlist(fn)
`endif
  );

  thermo_stim_checker #(.WIDTH(W), .SETTLE(S), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .stim(stim2),
    .golden_out(golden2), .netlist_out(netlist2),
    .busy(busy2), .done(done2), .pass(pass2), .mismatch_cnt(cnt2), .step(step2)
`ifdef THERMO_STIM_FAIL_CAPTURE_EN
    , .fail_valid(fv2), .fail_step(fs2), .fail_golden(fg2), .fail_netlist(fn2)
`endif
  );

  // k-ones mask from plain arithmetic.
  function automatic logic [W-1:0] tmask(input int k);
    logic [63:0] t;
    t = (64'd1 << k) - 64'd1;
    return W'(t);
  endfunction

  // Reference: walk the WIDTH+1 steps of an AND unit against the chosen netlist behaviour.
  function automatic void model(input int md, input int cw, output int ecnt, output int efs,
                                output logic efg, output logic efn);
    logic g, nv;
    ecnt = 0; efs = -1; efg = 1'b0; efn = 1'b0;
    for (int k = 0; k <= W; k++) begin
      g = (k == W);
      case (md)
        0:       nv = g;
        1:       nv = 1'b0;
        2:       nv = 1'b1;
        default: nv = xv;
      endcase
      if (g !== nv) begin
        if (efs < 0) begin efs = k; efg = g; efn = nv; end
        ecnt++;
      end
    end
    if (ecnt > (1 << cw) - 1) ecnt = (1 << cw) - 1;
  endfunction

  function automatic int clipk(input int v);
    return (v > W) ? W : v;
  endfunction

  task automatic test_reset();
    @(negedge clk);
    total++;
    if (stim !== '0 || busy !== 0 || done !== 0 || pass !== 0 || cnt !== '0 || step !== '0) begin
      bad++;
      $display("FAIL reset_hold: stim=%h busy=%b done=%b pass=%b cnt=%0d step=%0d want all zero",
               stim, busy, done, pass, cnt, step);
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (busy !== 0 || done !== 0 || stim !== '0) begin
      bad++;
      $display("FAIL idle_after_reset: busy=%b done=%b stim=%h want 0 0 00", busy, done, stim);
    end
  endtask

  task automatic run_and_check(input int md, input string name);
    int ecnt, efs, n, ks, kk;
    logic efg, efn;
    bit fin;
    mode = md;
    model(md, 8, ecnt, efs, efg, efn);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    total++;
    if (busy !== 1 || done !== 0 || pass !== 0 || cnt !== '0) begin
      bad++;
      $display("FAIL %s accept: busy=%b done=%b pass=%b cnt=%0d want 1 0 0 0", name, busy, done, pass, cnt);
    end
    n = 0; fin = 0;
    while (!fin) begin
      @(posedge clk);
      #1;
      n++;
      ks = clipk((n - 1) / (S + 2));
      kk = clipk(n / (S + 2));
      total++;
      if (stim !== tmask(ks) || step !== SWT'(kk)) begin
        bad++;
        $display("FAIL %s seq@%0d: stim=%h step=%0d want %h %0d", name, n, stim, step, tmask(ks), kk);
      end
      if (done === 1'b1) fin = 1;
      else if (busy !== 1'b1) begin
        total++; bad++;
        $display("FAIL %s busy@%0d: busy=%b want 1", name, n, busy);
      end
      if (!fin && n >= RUN + 10) begin
        total++; bad++;
        $display("FAIL %s timeout: cycles=%0d want done by %0d", name, n, RUN);
        fin = 1;
      end
    end
    total++;
    if (n != RUN) begin
      bad++;
      $display("FAIL %s latency: cycles=%0d want %0d", name, n, RUN);
    end
    total++;
    if (cnt !== 8'(ecnt) || pass !== (ecnt == 0) || busy !== 0) begin
      bad++;
      $display("FAIL %s result: cnt=%0d pass=%b busy=%b want %0d %b 0", name, cnt, pass, busy, ecnt, ecnt == 0);
    end
`ifdef THERMO_STIM_FAIL_CAPTURE_EN
    total++;
    if (fv !== (efs >= 0) || (efs >= 0 && (fs !== SWT'(efs) || fg !== efg || fn !== efn))) begin
      bad++;
      $display("FAIL %s capture: valid=%b step=%0d g=%b n=%b want %b %0d %b %b",
               name, fv, fs, fg, fn, efs >= 0, efs, efg, efn);
    end
`endif
  endtask

  task automatic test_match();    run_and_check(0, "match");   endtask
  task automatic test_stuck0();   run_and_check(1, "stuck0");  endtask
  task automatic test_stuck1();   run_and_check(2, "stuck1");  endtask
  task automatic test_xnetlist(); run_and_check(3, "xnet");    endtask

  task automatic test_reset_midrun();
    mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (17) @(posedge clk);
    #2;
    total++;
    if (step !== SWT'(4) || busy !== 1) begin
      bad++;
      $display("FAIL midrun_pos: step=%0d busy=%b want 4 1", step, busy);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (stim !== '0 || busy !== 0 || done !== 0 || pass !== 0 || cnt !== '0 || step !== '0) begin
      bad++;
      $display("FAIL async_reset: stim=%h busy=%b done=%b pass=%b cnt=%0d step=%0d want all zero",
               stim, busy, done, pass, cnt, step);
    end
`ifdef THERMO_STIM_FAIL_CAPTURE_EN
    total++;
    if (fv !== 0) begin
      bad++;
      $display("FAIL async_reset_cap: fail_valid=%b want 0", fv);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_and_check(0, "restart");
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      run_and_check(int'($urandom_range(0, 3)), "random");
    end
  endtask

  task automatic test_start_held();
    int n;
    bit fin;
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk);
    n = 0; fin = 0;
    while (!fin) begin
      @(posedge clk);
      #1;
      n++;
      if (done2 === 1'b1 || n >= RUN + 10) fin = 1;
    end
    total++;
    if (n != RUN) begin
      bad++;
      $display("FAIL held latency: cycles=%0d want %0d", n, RUN);
    end
    total++;
    if (cnt2 !== 2'd3 || pass2 !== 0) begin
      bad++;
      $display("FAIL held saturate: cnt=%0d pass=%b want 3 0", cnt2, pass2);
    end
    @(posedge clk);
    #1;
    total++;
    if (done2 !== 0 || busy2 !== 1 || cnt2 !== 2'd0) begin
      bad++;
      $display("FAIL held restart: done=%b busy=%b cnt=%0d want 0 1 0", done2, busy2, cnt2);
    end
    start2 = 1'b0;
  endtask

  initial begin
    xv = 1'bx;
    test_reset();
    test_match();
    test_stuck0();
    test_stuck1();
    test_xnetlist();
    test_reset_midrun();
    test_random();
    test_start_held();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
